ds_rsp_packer: RTL and testbench



---
 rtl/ds_rsp_packer.sv | 210 +++++++++++++++++++++
 tb/tb_ds_rsp_packer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_rsp_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ds_rsp_packer
//  Purpose  : Packs downstream read-response beats (BEAT_W bits) into
//             segments of two beats (SEG_W bits). Each segment is tagged with
//             the linefill command (buffer entry id, ROB id) that was
//             recorded when the downstream read was issued. A 2-entry FIFO
//             with registered outputs drives the ds_to_lfdb handshake.
//  Ports    : clk, rst_n (async, active low)
//             lf_cmd_*     : command capture into the per-id table
//             ds_rsp_*     : response beat handshake from downstream memory
//             ds_to_lfdb_* : segment handshake to the linefill data buffer
//             err          : sticky protocol error
//  Options  : DS_RSP_PACKER_ERR_CHK_EN builds the protocol checker; when it
//             is undefined err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ds_rsp_packer #(
  parameter int BEAT_W   = 512,
  parameter int SEG_W    = 1024,
  parameter int SEG_NUM  = 4,
  parameter int ID_W     = 4,
  parameter int DB_ID_W  = 2,
  parameter int ROB_ID_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lf_cmd_vld,
  output logic                lf_cmd_rdy,
  input  logic [ID_W-1:0]     lf_cmd_id,
  input  logic [DB_ID_W-1:0]  lf_cmd_db_id,
  input  logic [ROB_ID_W-1:0] lf_cmd_rob_id,
  input  logic                ds_rsp_vld,
  output logic                ds_rsp_rdy,
  input  logic [ID_W-1:0]     ds_rsp_id,
  input  logic [BEAT_W-1:0]   ds_rsp_data,
  input  logic                ds_rsp_last,
  output logic                ds_to_lfdb_vld,
  input  logic                ds_to_lfdb_rdy,
  output logic [SEG_W-1:0]    ds_to_lfdb_data,
  output logic [DB_ID_W-1:0]  ds_to_lfdb_db_id,
  output logic [ROB_ID_W-1:0] ds_to_lfdb_rob_id,
  output logic                ds_to_lfdb_last,
  output logic                err
);

  localparam int SLOTS = 1 << ID_W;
  localparam int CNT_W = $clog2(2 * SEG_NUM);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(2 * SEG_NUM - 1);

  typedef struct packed {
    logic [SEG_W-1:0]    data;
    logic [DB_ID_W-1:0]  db_id;
    logic [ROB_ID_W-1:0] rob_id;
    logic                last;
  } seg_t;

  // Command table
  logic [SLOTS-1:0]    slot_vld_q, slot_vld_d;
  logic [DB_ID_W-1:0]  slot_db_q  [SLOTS];
  logic [DB_ID_W-1:0]  slot_db_d  [SLOTS];
  logic [ROB_ID_W-1:0] slot_rob_q [SLOTS];
  logic [ROB_ID_W-1:0] slot_rob_d [SLOTS];

  // Beat packing; beat_cnt != 0 means a line is in progress
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]   low_half_q, low_half_d;

  // Output FIFO, entry 0 is the head
  seg_t                fifo_q [2];
  seg_t                fifo_d [2];
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;

  logic                fifo_pop;
  logic                rsp_acc;
  logic                seg_push;
  logic                seg_last;
  seg_t                new_seg;

  assign ds_to_lfdb_vld    = (fifo_cnt_q != 2'd0);
  assign ds_to_lfdb_data   = fifo_q[0].data;
  assign ds_to_lfdb_db_id  = fifo_q[0].db_id;
  assign ds_to_lfdb_rob_id = fifo_q[0].rob_id;
  assign ds_to_lfdb_last   = fifo_q[0].last;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_db_d  = slot_db_q;
    slot_rob_d = slot_rob_q;
    beat_cnt_d = beat_cnt_q;
    low_half_d = low_half_q;
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;

    fifo_pop   = ds_to_lfdb_vld && ds_to_lfdb_rdy;
    // Even beats only land in the low-half register, so they never need
    // FIFO space; odd beats need a free entry or a pop in the same cycle.
    ds_rsp_rdy = !beat_cnt_q[0] || (fifo_cnt_q < 2'd2) || fifo_pop;
    rsp_acc    = ds_rsp_vld && ds_rsp_rdy;
    seg_push   = rsp_acc && beat_cnt_q[0];
    seg_last   = (beat_cnt_q == LAST_BEAT);
    // Registered valid: a slot freed this cycle is reusable next cycle.
    lf_cmd_rdy = !slot_vld_q[lf_cmd_id];

    new_seg.data   = {ds_rsp_data, low_half_q};
    new_seg.db_id  = slot_db_q[ds_rsp_id];
    new_seg.rob_id = slot_rob_q[ds_rsp_id];
    new_seg.last   = seg_last;

    if (rsp_acc) begin
      beat_cnt_d = seg_last ? '0 : beat_cnt_q + CNT_W'(1);
      if (!beat_cnt_q[0]) begin
        low_half_d = ds_rsp_data;
      end
    end

    if (seg_push && seg_last) begin
      slot_vld_d[ds_rsp_id] = 1'b0;
    end

    // A new command can only target a slot whose registered valid is 0,
    // so it never collides with the clear above on the same slot.
    if (lf_cmd_vld && lf_cmd_rdy) begin
      slot_vld_d[lf_cmd_id] = 1'b1;
      slot_db_d[lf_cmd_id]  = lf_cmd_db_id;
      slot_rob_d[lf_cmd_id] = lf_cmd_rob_id;
    end

    case ({seg_push, fifo_pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) fifo_d[0] = new_seg;
        else                    fifo_d[1] = new_seg;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0]  = fifo_q[1];
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          fifo_d[0] = new_seg;
        end else begin
          fifo_d[0] = fifo_q[1];
          fifo_d[1] = new_seg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_db_q[i]  <= '0;
        slot_rob_q[i] <= '0;
      end
      beat_cnt_q <= '0;
      low_half_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_cnt_q <= 2'd0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_db_q  <= slot_db_d;
      slot_rob_q <= slot_rob_d;
      beat_cnt_q <= beat_cnt_d;
      low_half_q <= low_half_d;
      fifo_q     <= fifo_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

`ifdef DS_RSP_PACKER_ERR_CHK_EN
  logic            err_q, err_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;

  always_comb begin
    err_d    = err_q;
    cur_id_d = cur_id_q;
    if (rsp_acc) begin
      cur_id_d = ds_rsp_id;
      // Covers: unissued id, last on the wrong beat, missing last on the
      // final beat, and an id change inside a line.
      if (!slot_vld_q[ds_rsp_id] || (ds_rsp_last != seg_last) ||
          ((beat_cnt_q != '0) && (ds_rsp_id != cur_id_q))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      cur_id_q <= '0;
    end else begin
      err_q    <= err_d;
      cur_id_q <= cur_id_d;
    end
  end

  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = ds_rsp_last;
  assign err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ds_rsp_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ds_rsp_packer
//  Purpose  : Self-checking bench for ds_rsp_packer. A line-level model
//             (queue of expected segments, id table) is compared against the
//             DUT on every falling edge; directed scenarios add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ds_rsp_packer;
  localparam int BW = 512;
  localparam int SW = 1024;
  localparam int IW = 4;
  localparam int DW = 2;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lf_cmd_vld = 1'b0;
  logic          lf_cmd_rdy;
  logic [IW-1:0] lf_cmd_id = '0;
  logic [DW-1:0] lf_cmd_db_id = '0;
  logic [RW-1:0] lf_cmd_rob_id = '0;
  logic          ds_rsp_vld = 1'b0;
  logic          ds_rsp_rdy;
  logic [IW-1:0] ds_rsp_id = '0;
  logic [BW-1:0] ds_rsp_data = '0;
  logic          ds_rsp_last = 1'b0;
  logic          ds_to_lfdb_vld;
  logic          ds_to_lfdb_rdy = 1'b1;
  logic [SW-1:0] ds_to_lfdb_data;
  logic [DW-1:0] ds_to_lfdb_db_id;
  logic [RW-1:0] ds_to_lfdb_rob_id;
  logic          ds_to_lfdb_last;
  logic          err;

  always #5 clk = ~clk;

  ds_rsp_packer dut (
    .clk(clk), .rst_n(rst_n),
    .lf_cmd_vld(lf_cmd_vld), .lf_cmd_rdy(lf_cmd_rdy), .lf_cmd_id(lf_cmd_id),
    .lf_cmd_db_id(lf_cmd_db_id), .lf_cmd_rob_id(lf_cmd_rob_id),
    .ds_rsp_vld(ds_rsp_vld), .ds_rsp_rdy(ds_rsp_rdy), .ds_rsp_id(ds_rsp_id),
    .ds_rsp_data(ds_rsp_data), .ds_rsp_last(ds_rsp_last),
    .ds_to_lfdb_vld(ds_to_lfdb_vld), .ds_to_lfdb_rdy(ds_to_lfdb_rdy),
    .ds_to_lfdb_data(ds_to_lfdb_data), .ds_to_lfdb_db_id(ds_to_lfdb_db_id),
    .ds_to_lfdb_rob_id(ds_to_lfdb_rob_id), .ds_to_lfdb_last(ds_to_lfdb_last),
    .err(err)
  );

  typedef struct {
    logic [SW-1:0] data;
    logic [DW-1:0] db;
    logic [RW-1:0] rob;
    logic          last;
  } seg_t;

  seg_t          exp_q[$];
  seg_t          rx_q[$];
  logic          m_slot_v [16];
  logic [DW-1:0] m_db     [16];
  logic [RW-1:0] m_rob    [16];
  int            m_beat;
  logic [BW-1:0] m_low;
  logic          m_err;
  logic [IW-1:0] m_cur_id;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got hi=%0h lo=%0h expected hi=%0h lo=%0h (cycle %0d)",
               nm, act[575:512], act[63:0], exp[575:512], exp[63:0], cyc);
    end
  endtask

  function automatic logic [BW-1:0] pat(input int v);
    return {16{32'(v)}};
  endfunction

  // ---------------- line-level model ----------------
  task automatic model_step();
    bit   pop, rdy, acc, cacc;
    seg_t s;
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
        m_slot_v[i] = 1'b0; m_db[i] = '0; m_rob[i] = '0;
      end
      m_beat = 0; m_low = '0; m_err = 1'b0; m_cur_id = '0;
    end else begin
      pop  = (exp_q.size() > 0) && ds_to_lfdb_rdy;
      rdy  = (m_beat % 2 == 0) || (exp_q.size() < 2) || pop;
      acc  = ds_rsp_vld && rdy;
      cacc = lf_cmd_vld && !m_slot_v[lf_cmd_id];
      if (pop) exp_q.delete(0);
      if (acc) begin
`ifdef DS_RSP_PACKER_ERR_CHK_EN
        if (!m_slot_v[ds_rsp_id] || (ds_rsp_last != (m_beat == 7)) ||
            (m_beat != 0 && ds_rsp_id != m_cur_id))
          m_err = 1'b1;
`endif
        m_cur_id = ds_rsp_id;
        if (m_beat % 2 == 0) begin
          m_low = ds_rsp_data;
        end else begin
          s.data = {ds_rsp_data, m_low};
          s.db   = m_db[ds_rsp_id];
          s.rob  = m_rob[ds_rsp_id];
          s.last = (m_beat == 7);
          exp_q.push_back(s);
          if (m_beat == 7) m_slot_v[ds_rsp_id] = 1'b0;
        end
        m_beat = (m_beat + 1) % 8;
      end
      if (cacc) begin
        m_slot_v[lf_cmd_id] = 1'b1;
        m_db[lf_cmd_id]     = lf_cmd_db_id;
        m_rob[lf_cmd_id]    = lf_cmd_rob_id;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    seg_t r;
    @(negedge clk);
    chk("lfdb_vld", 64'(ds_to_lfdb_vld), 64'(exp_q.size() > 0));
    chk("rsp_rdy", 64'(ds_rsp_rdy),
        64'((m_beat % 2 == 0) || (exp_q.size() < 2) || ((exp_q.size() > 0) && ds_to_lfdb_rdy)));
    chk("cmd_rdy", 64'(lf_cmd_rdy), 64'(!m_slot_v[lf_cmd_id]));
    chk("err", 64'(err), 64'(m_err));
    if (!ds_rsp_rdy) stall_cnt++;
    if (exp_q.size() > 0) begin
      chk_data("seg_data", ds_to_lfdb_data, exp_q[0].data);
      chk("seg_db", 64'(ds_to_lfdb_db_id), 64'(exp_q[0].db));
      chk("seg_rob", 64'(ds_to_lfdb_rob_id), 64'(exp_q[0].rob));
      chk("seg_last", 64'(ds_to_lfdb_last), 64'(exp_q[0].last));
      if (ds_to_lfdb_vld && ds_to_lfdb_rdy) begin
        r.data = ds_to_lfdb_data; r.db = ds_to_lfdb_db_id;
        r.rob = ds_to_lfdb_rob_id; r.last = ds_to_lfdb_last;
        rx_q.push_back(r);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [IW-1:0] id, input logic [DW-1:0] db,
                          input logic [RW-1:0] rob, output int edge_no);
    bit ok, done;
    done = 0; edge_no = -1;
    lf_cmd_vld = 1'b1; lf_cmd_id = id; lf_cmd_db_id = db; lf_cmd_rob_id = rob;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      ok = lf_cmd_rdy;
      tick();
      if (ok) begin done = 1; edge_no = cyc; end
    end
    lf_cmd_vld = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_timeout: got no accept expected accept for id %0d", id);
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] id, input logic [BW-1:0] d,
                           input logic last, output int edge_no);
    bit ok, done;
    done = 0; edge_no = -1;
    ds_rsp_vld = 1'b1; ds_rsp_id = id; ds_rsp_data = d; ds_rsp_last = last;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      ok = ds_rsp_rdy;
      tick();
      if (ok) begin done = 1; edge_no = cyc; end
    end
    ds_rsp_vld = 1'b0; ds_rsp_last = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: got no accept expected accept for id %0d", id);
    end
  endtask

  // bad_at selects which beat carries last (7 for a well-formed line)
  task automatic send_line(input logic [IW-1:0] id, input int base, input int bad_at,
                           output int first_edge, output int last_edge);
    int e;
    for (int k = 0; k < 8; k++) begin
      send_beat(id, pat(base + k), 1'(k == bad_at), e);
      if (k == 0) first_edge = e;
      last_edge = e;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int e, e1, f0, l0, f1, l1, ld, ed;
    logic [SW-1:0] want;

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_vld", 64'(ds_to_lfdb_vld), 64'd0);
    chk("rst_data_lo", ds_to_lfdb_data[63:0], 64'd0);
    chk("rst_rob", 64'(ds_to_lfdb_rob_id), 64'd0);
    chk("rst_last", 64'(ds_to_lfdb_last), 64'd0);
    chk("rst_rsp_rdy", 64'(ds_rsp_rdy), 64'd1);
    chk("rst_cmd_rdy", 64'(lf_cmd_rdy), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single line, data = beat index
    rx_q.delete();
    send_cmd(4'd3, 2'd1, 6'd10, e);
    chk("cmd3_busy", 64'(lf_cmd_rdy), 64'd0);
    send_beat(4'd3, BW'(0), 1'b0, e);
    send_beat(4'd3, BW'(1), 1'b0, e);
    chk("latency_vld", 64'(ds_to_lfdb_vld), 64'd1);
    for (int k = 2; k < 8; k++) send_beat(4'd3, BW'(k), 1'(k == 7), e);
    chk("slot3_free", 64'(lf_cmd_rdy), 64'd1);
    repeat (4) tick();
    chk("single_cnt", 64'(rx_q.size()), 64'd4);
    if (rx_q.size() == 4) begin
      want = {512'd1, 512'd0};
      chk_data("single_seg0", rx_q[0].data, want);
      want = {512'd7, 512'd6};
      chk_data("single_seg3", rx_q[3].data, want);
      chk("single_last0", 64'(rx_q[0].last), 64'd0);
      chk("single_last3", 64'(rx_q[3].last), 64'd1);
      chk("single_db", 64'(rx_q[2].db), 64'd1);
      chk("single_rob", 64'(rx_q[1].rob), 64'd10);
    end

    // Backpressure: sink stalls 10 cycles mid-line
    rx_q.delete(); stall_cnt = 0;
    send_cmd(4'd4, 2'd2, 6'd20, e);
    fork
      send_line(4'd4, 100, 7, f0, l0);
      begin
        repeat (3) tick();
        ds_to_lfdb_rdy = 1'b0;
        repeat (10) tick();
        ds_to_lfdb_rdy = 1'b1;
      end
    join
    repeat (6) tick();
    chk("bp_stalled", 64'(stall_cnt > 0), 64'd1);
    chk("bp_cnt", 64'(rx_q.size()), 64'd4);
    if (rx_q.size() == 4)
      for (int k = 0; k < 4; k++)
        chk_data("bp_order", rx_q[k].data, {pat(101 + 2 * k), pat(100 + 2 * k)});

    // Two ids back to back
    rx_q.delete();
    send_cmd(4'd0, 2'd0, 6'd5, e);
    send_cmd(4'd1, 2'd3, 6'd6, e);
    send_line(4'd0, 200, 7, f0, l0);
    send_line(4'd1, 300, 7, f1, l1);
    chk("b2b_span", 64'(l1 - f0), 64'd15);
    repeat (4) tick();
    chk("b2b_cnt", 64'(rx_q.size()), 64'd8);
    if (rx_q.size() == 8) begin
      chk("b2b_rob3", 64'(rx_q[3].rob), 64'd5);
      chk("b2b_rob4", 64'(rx_q[4].rob), 64'd6);
      chk("b2b_db4", 64'(rx_q[4].db), 64'd3);
      chk("b2b_last7", 64'(rx_q[7].last), 64'd1);
    end

    // Duplicate command on a busy slot
    rx_q.delete();
    send_cmd(4'd2, 2'd1, 6'd30, e);
    fork
      begin repeat (2) tick(); send_line(4'd2, 400, 7, f0, ld); end
      send_cmd(4'd2, 2'd2, 6'd31, ed);
    join
    chk("dup_accept_edge", 64'(ed), 64'(ld + 1));
    send_line(4'd2, 500, 7, f0, l0);
    repeat (4) tick();
    chk("dup_cnt", 64'(rx_q.size()), 64'd8);
    if (rx_q.size() == 8) begin
      chk("dup_rob_old", 64'(rx_q[3].rob), 64'd30);
      chk("dup_rob_new", 64'(rx_q[4].rob), 64'd31);
    end

    // Protocol errors: last on beat 5, then a line for an unissued id
    send_cmd(4'd5, 2'd1, 6'd40, e);
    send_line(4'd5, 600, 5, f0, l0);
    tick();
`ifdef DS_RSP_PACKER_ERR_CHK_EN
    chk("err_bad_last", 64'(err), 64'd1);
`else
    chk("err_bad_last", 64'(err), 64'd0);
`endif
    repeat (3) tick();
    do_reset();
    chk("err_cleared", 64'(err), 64'd0);
    send_line(4'd9, 700, 7, f0, l0);
    tick();
`ifdef DS_RSP_PACKER_ERR_CHK_EN
    chk("err_unissued", 64'(err), 64'd1);
`else
    chk("err_unissued", 64'(err), 64'd0);
`endif
    repeat (3) tick();
    do_reset();

    // Reset in the middle of a line
    send_cmd(4'd6, 2'd3, 6'd50, e);
    for (int k = 0; k < 3; k++) send_beat(4'd6, pat(900 + k), 1'b0, e1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(ds_to_lfdb_vld), 64'd0);
    chk("mid_rst_rsp_rdy", 64'(ds_rsp_rdy), 64'd1);
    chk("mid_rst_cmd_rdy", 64'(lf_cmd_rdy), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rx_q.delete();
    send_cmd(4'd6, 2'd3, 6'd51, e);
    send_line(4'd6, 800, 7, f0, l0);
    repeat (4) tick();
    chk("post_rst_cnt", 64'(rx_q.size()), 64'd4);
    if (rx_q.size() == 4) begin
      chk_data("post_rst_seg0", rx_q[0].data, {pat(801), pat(800)});
      chk("post_rst_rob", 64'(rx_q[0].rob), 64'd51);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
